lna_rx_deframer: RTL
====================

Name: lna_rx_deframer

Overview:
Receive-side stage directly downstream of the post-LNA differential chain. It consumes the single-bit InnerReceive line and oversamples it on the local clock. It recovers bit timing, hunts for a sync word, and deserialises a fixed-length frame into bytes. Bytes reach the digital back end through a small FIFO with a valid/ready handshake.

Parameters:
OVERSAMPLE, 4, clocks per line bit (power of two, >=4)
SYNC_WIDTH, 16, sync word length in bits
SYNC_WORD, 16'hA5C3, sync pattern, MSB received first
FRAME_BYTES, 4, payload bytes per frame after sync (1..255)
FIFO_DEPTH, 4, byte FIFO entries (power of two)

Ports:
Clk  input  1  sole clock
ResetN  input  1  asynchronous active-low reset
InnerReceive  input  1  serial receive line from the post-LNA stage, asynchronous to Clk
Enable  input  1  deframer run enable
RxData  output  8  payload byte
RxValid  output  1  RxData valid
RxReady  input  1  consumer accepts byte
RxFirst  output  1  RxData is byte 0 of a frame
RxLast  output  1  RxData is byte FRAME_BYTES-1
SyncLocked  output  1  high while in PAYLOAD state
Overflow  output  1  one-cycle pulse when a byte is dropped

Behaviour:
- Clk is the single clock. ResetN is asynchronous and active-low. Reset clears all state, FIFO and counters.
- Reset values: RxData=0, RxValid=0, RxFirst=0, RxLast=0, SyncLocked=0, Overflow=0. State resets to HUNT.
- Input: 2-flop synchroniser on InnerReceive, adding 2 cycles of latency. A third flop provides edge detect (sync vs previous sync). The line must be driven, never Z, while Enable=1.
- Bit timing: phase counter 0..OVERSAMPLE-1.
  - A detected edge loads phase=0. Otherwise phase increments and wraps.
  - Bit strobe fires when phase==OVERSAMPLE/2 and samples the synchronised bit.
- States: HUNT, PAYLOAD.
- HUNT:
  - On each strobe, shift the bit into a SYNC_WIDTH shift register.
  - When the post-shift register equals SYNC_WORD, go to PAYLOAD the next cycle with bitcnt=0 and bytecnt=0.
- PAYLOAD:
  - Bits assemble MSB-first.
  - On the 8th strobe the byte is pushed, tagged first=(bytecnt==0) and last=(bytecnt==FRAME_BYTES-1), and bytecnt increments.
  - After the last push, go to HUNT with the shift register cleared to 0, so sync must be fully re-received.
- SyncLocked is a registered copy of (state==PAYLOAD).
- Enable=0: next cycle returns to HUNT and clears the shift register and counters. FIFO contents are kept and remain drainable. Enable deasserted mid-frame gives a truncated frame with no RxLast.
- FIFO:
  - A push is accepted when count<FIFO_DEPTH, or when a pop happens in the same cycle.
  - A simultaneous push and pop leaves count unchanged.
  - A byte written into an empty FIFO shows RxValid=1 on the next cycle. Latency from the 8th bit strobe to RxValid is 1 clock.
- Handshake:
  - Pop occurs when RxValid&&RxReady.
  - While RxValid=1 and RxReady=0, RxData, RxFirst and RxLast hold stable.
  - RxValid never drops without a pop, except on reset.
- Overflow:
  - A push refused due to full raises Overflow for 1 cycle.
  - The byte is dropped, the frame is aborted and the state returns to HUNT. Bytes already queued are retained; the consumer sees a frame without RxLast.
- Wrap-around: the FIFO pointers have one extra bit for full/empty distinction. The phase and bit counters wrap modulo their ranges.
- A sync-word match that ends exactly on the same strobe where Enable falls is ignored; Enable takes priority.

Decomposition:
- Package lna_rx_pkg holds:
  - the state enum (HUNT, PAYLOAD)
  - the BYTE_W=8 constant
  - default SYNC_WORD/SYNC_WIDTH constants
  - the FIFO entry struct {data[7:0], first, last}
- One sub-module, lna_rx_fifo, parameterised by depth and entry width. It is a synchronous FIFO with push/pop/full/empty and the same Clk/ResetN.

Test Plan:
1. Parameters OVERSAMPLE=4, FRAME_BYTES=4. Send A5C3 then 11 22 33 44 at 4 clk/bit with RxReady=1 -> RxData 11(first),22,33,44(last). SyncLocked high from sync end through the last byte. Overflow never fires.
2. Same frame with RxReady=0 throughout and FIFO_DEPTH=4 -> four bytes held, RxValid=1, RxData stays 11. Then send a second frame -> Overflow pulses once on its first byte and the state returns to HUNT. Releasing RxReady drains 11,22,33,44 only.
3. Send sync A5C2 (1 bit off) followed by 11 22 33 44 -> no RxValid and SyncLocked stays 0. Then send a correct A5C3 frame -> that frame is delivered normally.
4. Line bit period jittered to 3 and 5 clocks alternately with an edge on every bit (alternating 55 AA payload after sync) -> bytes 55 AA 55 AA recovered exactly.
5. Drop Enable after 12 payload bits of a frame -> byte 11 delivered with RxFirst=1 and no further bytes. Re-enable and send a full frame -> delivered correctly.
6. Assert ResetN=0 asynchronously mid-frame with 2 bytes queued -> all outputs 0 within the same cycle, FIFO empty. After release, the next frame is received cleanly.

Source files
------------

// File: rtl/lna_rx_pkg.sv
// Shared types and constants for the LNA receive deframer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lna_rx_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam int          BYTE_W         = 8;
    localparam int          SYNC_WIDTH_DEF = 16;
    localparam logic [15:0] SYNC_WORD_DEF  = 16'hA5C3;

    // One queued payload byte plus its frame-position tags.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              first;
        logic              last;
    } entry_t;

endpackage

// File: rtl/lna_rx_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty distinction.
// Latency: a push into an empty FIFO is visible (empty=0) on the next cycle.
// Backpressure: push_rdy is low only when full and no pop this cycle.
module lna_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_rdy = !full || pop_ok;
    assign push_ok  = push && push_rdy;
    assign pop_dat  = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lna_rx_deframer.sv
// Oversampling serial deframer: sync-word hunt, fixed-length byte deserialise, byte FIFO.
// Latency: line to strobe ~OVERSAMPLE/2+3 clocks; 8th bit strobe to RxValid is 1 clock.
// Backpressure: RxReady stalls the FIFO head; a byte arriving while full is dropped and the frame aborted.
module lna_rx_deframer
    import lna_rx_pkg::*;
#(
    parameter int                    OVERSAMPLE  = 4,
    parameter int                    SYNC_WIDTH  = SYNC_WIDTH_DEF,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = SYNC_WIDTH'(SYNC_WORD_DEF),
    parameter int                    FRAME_BYTES = 4,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              InnerReceive,
    input  logic              Enable,
    output logic [BYTE_W-1:0] RxData,
    output logic              RxValid,
    input  logic              RxReady,
    output logic              RxFirst,
    output logic              RxLast,
    output logic              SyncLocked,
    output logic              Overflow
);

    localparam int       PW        = $clog2(OVERSAMPLE);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

    logic                  sync1, sync2, sync3;
    logic                  line_edge;
    logic [PW-1:0]         phase_q, phase_cur;
    logic                  strobe;

    state_t                state, state_n;
    logic [SYNC_WIDTH-1:0] hunt_sr, hunt_sr_n;
    logic [BYTE_W-2:0]     byte_sr, byte_sr_n;
    logic [2:0]            bitcnt, bitcnt_n;
    logic [7:0]            bytecnt, bytecnt_n;
    logic                  ovf_n;

    logic                  push;
    entry_t                push_ent;
    logic                  push_rdy;
    entry_t                head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Two-flop synchroniser plus a history flop for transition detection.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= InnerReceive;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // The cycle an edge is seen counts as phase 0, so the strobe lands mid-bit.
    assign line_edge = sync2 ^ sync3;
    assign phase_cur = line_edge ? '0 : phase_q;
    assign strobe    = (phase_cur == PW'(OVERSAMPLE / 2));

    // Free-running bit-phase counter, realigned by every line transition.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_cur + PW'(1);
        end
    end

    // Next-state logic: sync hunt, byte assembly, push/abort decisions.
    always_comb begin
        state_n   = state;
        hunt_sr_n = hunt_sr;
        byte_sr_n = byte_sr;
        bitcnt_n  = bitcnt;
        bytecnt_n = bytecnt;
        ovf_n     = 1'b0;
        push      = 1'b0;
        push_ent  = '0;
        if (!Enable) begin
            state_n   = HUNT;
            hunt_sr_n = '0;
            byte_sr_n = '0;
            bitcnt_n  = '0;
            bytecnt_n = '0;
        end else if (strobe) begin
            case (state)
                HUNT: begin
                    hunt_sr_n = {hunt_sr[SYNC_WIDTH-2:0], sync2};
                    if (hunt_sr_n == SYNC_WORD) begin
                        state_n   = PAYLOAD;
                        bitcnt_n  = '0;
                        bytecnt_n = '0;
                    end
                end
                PAYLOAD: begin
                    byte_sr_n = {byte_sr[BYTE_W-3:0], sync2};
                    bitcnt_n  = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        push           = 1'b1;
                        push_ent.data  = {byte_sr, sync2};
                        push_ent.first = (bytecnt == 8'd0);
                        push_ent.last  = (bytecnt == LAST_IDX);
                        if (push_rdy) begin
                            bytecnt_n = bytecnt + 8'd1;
                            if (push_ent.last) begin
                                state_n   = HUNT;
                                hunt_sr_n = '0;
                            end
                        end else begin
                            // Dropped byte: abandon the frame and demand a fresh sync.
                            ovf_n     = 1'b1;
                            state_n   = HUNT;
                            hunt_sr_n = '0;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // Deframer state register and registered status outputs.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= HUNT;
            hunt_sr    <= '0;
            byte_sr    <= '0;
            bitcnt     <= '0;
            bytecnt    <= '0;
            Overflow   <= 1'b0;
            SyncLocked <= 1'b0;
        end else begin
            state      <= state_n;
            hunt_sr    <= hunt_sr_n;
            byte_sr    <= byte_sr_n;
            bitcnt     <= bitcnt_n;
            bytecnt    <= bytecnt_n;
            Overflow   <= ovf_n;
            SyncLocked <= (state == PAYLOAD);
        end
    end

    lna_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .push     (push),
        .push_dat (push_ent),
        .push_rdy (push_rdy),
        .pop      (RxValid && RxReady),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign RxValid = !fifo_empty;
    assign RxData  = head.data;
    assign RxFirst = head.first;
    assign RxLast  = head.last;

endmodule
